network_sequencer: RTL and testbench
====================================

NETWORK_SEQUENCER -- requirements
Module: network_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter N_LAYERS, default 3: number of conv stages sequenced, minimum 2.
REQ-003 Parameter CNT_W, default 32: width of the statistics counters.
REQ-004 Parameter TIMEOUT, default 4096: maximum number of RUN cycles per layer.
REQ-005 Port clk, input, 1: system clock.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port sample_clk, input, 1: sample strobe, synchronous to clk.
REQ-008 Port in_shift, output, 1: one-cycle advance pulse to the input shift buffers.
REQ-009 Port conv_rst, output, N_LAYERS: per-layer one-cycle start/reset pulse.
REQ-010 Port conv_out_v, input, N_LAYERS: per-layer result valid, held high until that layer's next conv_rst.
REQ-011 Port cache_clk, output, N_LAYERS-1: per-layer one-cycle capture pulse to activation cache i.
REQ-012 Port out_latch, output, 1: one-cycle pulse; the final layer output is valid to latch.
REQ-013 Port busy, output, 1: high whenever state is not IDLE.
REQ-014 Port overrun_count, output, CNT_W: saturating count of sample edges dropped while busy.
REQ-015 Port cycles_last, output, CNT_W: clk cycles from edge detect to LATCH of the last completed pass.
REQ-016 Port timeout_err, output, 1: sticky flag; a layer exceeded TIMEOUT.

Function
REQ-017 Rising edge SHALL be detected when sample_clk is 1 and its value registered on the previous cycle (prev) is 0.
REQ-018 States SHALL be: IDLE, SHIFT_IN, START, RUN, CACHE, LATCH, with a layer index idx (0..N_LAYERS-1).
REQ-019 IDLE plus edge -> SHIFT_IN, with idx set to 0 and the cycle counter cleared; with no edge, IDLE is held.
REQ-020 SHIFT_IN: in_shift=1 for that cycle only -> START.
REQ-021 START: conv_rst[idx]=1 for that cycle only, timeout counter cleared -> RUN.
REQ-022 RUN: conv_out_v[idx] is ignored in the first RUN cycle (blanking); from the second RUN cycle on, out_v=1 -> CACHE if idx<N_LAYERS-1, else -> LATCH.
REQ-023 CACHE: cache_clk[idx]=1 for that cycle only, idx incremented -> START.
REQ-024 LATCH: out_latch=1 for that cycle only, cycles_last loaded -> IDLE.
REQ-025 RUN timeout: if TIMEOUT RUN cycles elapse without valid out_v, timeout_err is set, the FSM returns to IDLE with no LATCH, and cycles_last is unchanged.
REQ-026 An edge while busy SHALL NOT restart the sequence; it increments overrun_count, which saturates at all-ones.
REQ-027 An edge in the same cycle the FSM returns to IDLE from LATCH counts as an overrun; an edge observed in IDLE starts a pass.
REQ-028 cycles_last SHALL equal the LATCH cycle index minus the edge-detect cycle index.
REQ-029 At most one bit of conv_rst and of cache_clk SHALL be high in any cycle; all outputs SHALL be registered.

Reset
REQ-030 rst SHALL asynchronously force: state IDLE, idx 0, prev 0, all pulse outputs 0, busy 0, overrun_count 0, cycles_last 0, timeout_err 0.
REQ-031 Reset mid-pass SHALL abort the pass with no further pulses; after release, a sample_clk held high produces no edge until it falls and rises again.

Structure
REQ-032 Shared package network_pkg SHALL hold the state enum and the N_LAYERS, CNT_W and TIMEOUT defaults.
REQ-033 A single sub-module, rising_edge_detect (prev register plus compare), SHALL be instantiated; everything else lives in network_sequencer.

Verification
REQ-034 Bench conv model: out_v[i] rises 4 cycles after conv_rst[i]. N_LAYERS=3, edge at cycle 0 -> in_shift@1, conv_rst[0]@2, cache_clk[0]@7, conv_rst[1]@8, cache_clk[1]@13, conv_rst[2]@14, out_latch@19; cycles_last=19.
REQ-035 Second edge at cycle 10 of a pass -> no restart, overrun_count=1, out_latch still at cycle 19.
REQ-036 conv_out_v[1] held 0, TIMEOUT=16 -> timeout_err=1, no out_latch, busy low after timeout, next edge runs a normal pass.
REQ-037 rst asserted at cycle 9 with sample_clk held high -> all outputs 0 immediately; no pass starts until sample_clk goes 0 then 1.
REQ-038 CNT_W=4, 20 overrun edges -> overrun_count=15.
REQ-039 conv_out_v[0] stale high at START -> blanking cycle ignored; CACHE only when out_v is high from the second RUN cycle onward.

Source files
------------

// File: rtl/network_pkg.sv
// Shared types and default sizing for the conv-stage network sequencer.
package network_pkg;

   localparam int N_LAYERS_DEF = 3;
   localparam int CNT_W_DEF    = 32;
   localparam int TIMEOUT_DEF  = 4096;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_IN = 3'd1,
      START    = 3'd2,
      RUN      = 3'd3,
      CACHE    = 3'd4,
      LATCH    = 3'd5
   } state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// Rising-edge detector on a clk-synchronous strobe.
// Held-high input after reset does not count as an edge until it has been seen low.
module rising_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic prev;
   logic armed;

   // Previous-value register plus arming flag, set once sig is observed low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev  <= 1'b0;
         armed <= 1'b0;
      end else begin
         prev  <= sig;
         armed <= armed | ~sig;
      end
   end

   assign rise = sig & ~prev & armed;

endmodule

// File: rtl/network_sequencer.sv
// Sequences a pass through N_LAYERS conv stages per sample strobe edge,
// with overrun/latency statistics and a per-layer RUN timeout.
module network_sequencer
   import network_pkg::*;
#(
   parameter int N_LAYERS = N_LAYERS_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sample_clk,
   output logic                  in_shift,
   output logic [N_LAYERS-1:0]   conv_rst,
   input  logic [N_LAYERS-1:0]   conv_out_v,
   output logic [N_LAYERS-2:0]   cache_clk,
   output logic                  out_latch,
   output logic                  busy,
   output logic [CNT_W-1:0]      overrun_count,
   output logic [CNT_W-1:0]      cycles_last,
   output logic                  timeout_err
);

   localparam int IDX_W = $clog2(N_LAYERS);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAYERS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [CNT_W-1:0]   cyc_cnt;
   logic               rise;

   rising_edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (sample_clk),
      .rise (rise)
   );

   // Sequencer FSM; pulse outputs are registered alongside the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         tmo_cnt       <= '0;
         cyc_cnt       <= '0;
         in_shift      <= 1'b0;
         conv_rst      <= '0;
         cache_clk     <= '0;
         out_latch     <= 1'b0;
         busy          <= 1'b0;
         overrun_count <= '0;
         cycles_last   <= '0;
         timeout_err   <= 1'b0;
      end else begin
         in_shift  <= 1'b0;
         conv_rst  <= '0;
         cache_clk <= '0;
         out_latch <= 1'b0;

         if (rise && (state != IDLE) && (overrun_count != '1)) begin
            overrun_count <= overrun_count + CNT_W'(1);
         end
         if (state != IDLE) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
         end

         case (state)
            IDLE: begin
               if (rise) begin
                  state    <= SHIFT_IN;
                  idx      <= '0;
                  cyc_cnt  <= '0;
                  in_shift <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            SHIFT_IN: begin
               state    <= START;
               conv_rst <= N_LAYERS'(1) << idx;
            end
            START: begin
               state   <= RUN;
               tmo_cnt <= '0;
            end
            RUN: begin
               // tmo_cnt == 0 marks the blanking cycle: a stale valid is ignored there.
               if ((tmo_cnt != '0) && conv_out_v[idx]) begin
                  if (idx == LAST_IDX) begin
                     state     <= LATCH;
                     out_latch <= 1'b1;
                  end else begin
                     state     <= CACHE;
                     cache_clk <= (N_LAYERS - 1)'(1) << idx;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            CACHE: begin
               state    <= START;
               idx      <= idx + IDX_W'(1);
               conv_rst <= N_LAYERS'(1) << (idx + IDX_W'(1));
            end
            LATCH: begin
               state       <= IDLE;
               busy        <= 1'b0;
               cycles_last <= cyc_cnt + CNT_W'(1);
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: table-driven pass timing plus
// overrun, blanking, timeout, reset and counter-saturation sequences.
module tb_network_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample = 1'b0;
   logic [2:0]  cv = 3'b000;
   logic        in_shift, out_latch, busy, timeout_err;
   logic [2:0]  conv_rst;
   logic [1:0]  cache_clk;
   logic [31:0] overrun_count, cycles_last;

   logic        sample2 = 1'b0;
   logic [2:0]  cv2 = 3'b000;
   logic        in_shift2, out_latch2, busy2, timeout_err2;
   logic [2:0]  conv_rst2;
   logic [1:0]  cache_clk2;
   logic [3:0]  overrun_count2, cycles_last2;

   int checks = 0;
   int errors = 0;
   logic stale = 1'b0;
   logic stuck1 = 1'b0;
   int mc [3] = '{0, 0, 0};

   network_sequencer #(.N_LAYERS(3), .CNT_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .sample_clk(sample), .in_shift(in_shift),
      .conv_rst(conv_rst), .conv_out_v(cv), .cache_clk(cache_clk),
      .out_latch(out_latch), .busy(busy), .overrun_count(overrun_count),
      .cycles_last(cycles_last), .timeout_err(timeout_err)
   );

   network_sequencer #(.N_LAYERS(3), .CNT_W(4), .TIMEOUT(16)) dut2 (
      .clk(clk), .rst(rst), .sample_clk(sample2), .in_shift(in_shift2),
      .conv_rst(conv_rst2), .conv_out_v(cv2), .cache_clk(cache_clk2),
      .out_latch(out_latch2), .busy(busy2), .overrun_count(overrun_count2),
      .cycles_last(cycles_last2), .timeout_err(timeout_err2)
   );

   always #5 clk = ~clk;

   // Conv stage model: valid rises 4 cycles after conv_rst, held until the next conv_rst.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (conv_rst[i]) begin
            mc[i] <= 1;
            if (!(stale && i == 0)) cv[i] <= 1'b0;
         end else if (mc[i] != 0) begin
            mc[i] <= mc[i] + 1;
            if (mc[i] == 1 && stale && i == 0) cv[0] <= 1'b0;
            if (mc[i] == 3) begin
               mc[i] <= 0;
               if (!(stuck1 && i == 1)) cv[i] <= 1'b1;
            end
         end
      end
   end

   typedef struct {
      int         off;
      logic       in_shift;
      logic [2:0] conv_rst;
      logic [1:0] cache_clk;
      logic       out_latch;
      logic       busy;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One pass from an edge at offset 0; optional extra edge at offset 'extra'.
   task automatic run_pass(input int extra);
      int off;
      off = 0;
      @(posedge clk); #1;
      sample = 1'b1;
      for (int k = 0; k < 11; k++) begin
         while (off < vt[k].off) begin
            @(posedge clk); #1;
            off++;
            sample = (off == extra);
         end
         @(negedge clk);
         chk($sformatf("in_shift@%0d", off), 64'(in_shift), 64'(vt[k].in_shift));
         chk($sformatf("conv_rst@%0d", off), 64'(conv_rst), 64'(vt[k].conv_rst));
         chk($sformatf("cache_clk@%0d", off), 64'(cache_clk), 64'(vt[k].cache_clk));
         chk($sformatf("out_latch@%0d", off), 64'(out_latch), 64'(vt[k].out_latch));
         chk($sformatf("busy@%0d", off), 64'(busy), 64'(vt[k].busy));
      end
   endtask

   initial begin
      logic seen_latch;
      int off;

      vt[0]  = '{0,  1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
      vt[1]  = '{1,  1'b1, 3'b000, 2'b00, 1'b0, 1'b1};
      vt[2]  = '{2,  1'b0, 3'b001, 2'b00, 1'b0, 1'b1};
      vt[3]  = '{3,  1'b0, 3'b000, 2'b00, 1'b0, 1'b1};
      vt[4]  = '{7,  1'b0, 3'b000, 2'b01, 1'b0, 1'b1};
      vt[5]  = '{8,  1'b0, 3'b010, 2'b00, 1'b0, 1'b1};
      vt[6]  = '{13, 1'b0, 3'b000, 2'b10, 1'b0, 1'b1};
      vt[7]  = '{14, 1'b0, 3'b100, 2'b00, 1'b0, 1'b1};
      vt[8]  = '{18, 1'b0, 3'b000, 2'b00, 1'b0, 1'b1};
      vt[9]  = '{19, 1'b0, 3'b000, 2'b00, 1'b1, 1'b1};
      vt[10] = '{20, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst conv_rst", 64'(conv_rst), 64'd0);
      chk("rst overrun", 64'(overrun_count), 64'd0);
      chk("rst cycles_last", 64'(cycles_last), 64'd0);
      chk("rst timeout_err", 64'(timeout_err), 64'd0);

      // Plain pass.
      run_pass(-1);
      chk("cycles_last p1", 64'(cycles_last), 64'd19);
      chk("overrun p1", 64'(overrun_count), 64'd0);

      // Edge at cycle 10 while busy.
      run_pass(10);
      chk("overrun p2", 64'(overrun_count), 64'd1);
      chk("cycles_last p2", 64'(cycles_last), 64'd19);

      // Layer 0 valid stale through the blanking cycle.
      stale = 1'b1;
      run_pass(-1);
      stale = 1'b0;

      // Layer 1 never completes: timeout.
      stuck1 = 1'b1;
      seen_latch = 1'b0;
      @(posedge clk); #1;
      sample = 1'b1;
      off = 0;
      while (off <= 30) begin
         @(negedge clk);
         if (out_latch) seen_latch = 1'b1;
         if (off == 24) begin
            chk("tmo busy@24", 64'(busy), 64'd1);
            chk("tmo err@24", 64'(timeout_err), 64'd0);
         end
         if (off == 25) begin
            chk("tmo busy@25", 64'(busy), 64'd0);
            chk("tmo err@25", 64'(timeout_err), 64'd1);
         end
         @(posedge clk); #1;
         off++;
         sample = 1'b0;
      end
      chk("tmo no latch", 64'(seen_latch), 64'd0);
      chk("tmo cycles_last", 64'(cycles_last), 64'd19);
      stuck1 = 1'b0;
      run_pass(-1);
      chk("tmo sticky", 64'(timeout_err), 64'd1);

      // Reset mid-pass with sample held high.
      @(posedge clk); #1;
      sample = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
      end
      chk("pre-rst busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid rst busy", 64'(busy), 64'd0);
      chk("mid rst conv_rst", 64'(conv_rst), 64'd0);
      chk("mid rst cache_clk", 64'(cache_clk), 64'd0);
      chk("mid rst overrun", 64'(overrun_count), 64'd0);
      chk("mid rst cycles_last", 64'(cycles_last), 64'd0);
      chk("mid rst timeout_err", 64'(timeout_err), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("held high busy %0d", c), 64'(busy), 64'd0);
         chk($sformatf("held high in_shift %0d", c), 64'(in_shift), 64'd0);
         @(posedge clk); #1;
      end
      sample = 1'b0;
      run_pass(-1);
      chk("post-rst cycles_last", 64'(cycles_last), 64'd19);

      // Saturation on a 4-bit overrun counter.
      for (int p = 0; p < 3; p++) begin
         @(posedge clk); #1;
         sample2 = 1'b1;
         for (int o = 1; o <= 22; o++) begin
            @(posedge clk); #1;
            sample2 = (o >= 2 && o <= 18 && (o % 2) == 0);
         end
         @(negedge clk);
         chk($sformatf("dut2 idle pass %0d", p), 64'(busy2), 64'd0);
         if (p == 0) chk("overrun 9", 64'(overrun_count2), 64'd9);
      end
      chk("overrun sat", 64'(overrun_count2), 64'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
